// File: rtl/anneal_ctrl.sv
// Sequencer for the annealing node array: per-iteration opt / exp pipeline
// strobes with a rising inverse temperature, then a distance readout.
module anneal_ctrl #(
  parameter int NODE_NUM = 32,
  parameter int EXP_LEN  = 17,
  parameter int OPT_LAT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] iter_num,
  input  logic [16:0] recip_init,
  input  logic [16:0] recip_step,
  output logic        busy,
  output logic        done,
  output logic        opt_run,
  output logic        exp_init,
  output logic        exp_run,
  output logic        exp_fin,
  output logic [16:0] exp_recip,
  output logic        distance_shift,
  output logic [31:0] iter_cnt
);

  localparam int MAX_OE = (OPT_LAT > EXP_LEN) ? OPT_LAT : EXP_LEN;
  localparam int CW     = (MAX_OE > NODE_NUM) ? MAX_OE : NODE_NUM;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPT   = 3'd1,
    WAIT  = 3'd2,
    EINIT = 3'd3,
    ERUN  = 3'd4,
    EFIN  = 3'd5,
    SHIFT = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          abort_pend_r, abort_pend_nxt_s;
  logic [31:0]   iter_num_r;
  logic [16:0]   recip_step_r;
  logic          last_iter_s;

  // Saturating 17-bit add, evaluated at 18 bits.
  function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[17] ? 17'h1FFFF : sum[16:0];
  endfunction

  // Remaining-cycle count loaded on entry; single-cycle states load zero.
  function automatic logic [CW-1:0] entry_len(input state_t s);
    case (s)
      WAIT:    entry_len = CW'(OPT_LAT - 1);
      ERUN:    entry_len = CW'(EXP_LEN - 1);
      SHIFT:   entry_len = CW'(NODE_NUM - 1);
      default: entry_len = CNT_ZERO;
    endcase
  endfunction

  assign last_iter_s = ((iter_cnt + 32'd1) == iter_num_r);

  // Next-state, counter and pending-abort logic.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    abort_pend_nxt_s = abort_pend_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = (iter_num == 32'd0) ? SHIFT : OPT;
               else       state_nxt_s = IDLE;
      OPT:     state_nxt_s = WAIT;
      WAIT:    if (cnt_r == CNT_ZERO) state_nxt_s = EINIT;
               else                   state_nxt_s = WAIT;
      EINIT:   state_nxt_s = ERUN;
      ERUN:    if (cnt_r == CNT_ZERO) state_nxt_s = EFIN;
               else                   state_nxt_s = ERUN;
      EFIN:    if (last_iter_s || abort_pend_r || abort) state_nxt_s = SHIFT;
               else                                      state_nxt_s = OPT;
      SHIFT:   if (cnt_r == CNT_ZERO) state_nxt_s = DONE;
               else                   state_nxt_s = SHIFT;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase

    if (state_nxt_s != state_r) begin
      cnt_nxt_s = entry_len(state_nxt_s);
    end else if (state_r == IDLE) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end

    if (state_nxt_s == SHIFT) begin
      abort_pend_nxt_s = 1'b0;
    end else if (state_r inside {OPT, WAIT, EINIT, ERUN, EFIN}) begin
      abort_pend_nxt_s = abort_pend_r | abort;
    end else begin
      abort_pend_nxt_s = abort_pend_r;
    end
  end

  // State register and strobes registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      cnt_r          <= CNT_ZERO;
      abort_pend_r   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      opt_run        <= 1'b0;
      exp_init       <= 1'b0;
      exp_run        <= 1'b0;
      exp_fin        <= 1'b0;
      distance_shift <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      abort_pend_r   <= abort_pend_nxt_s;
      busy           <= (state_nxt_s != IDLE);
      done           <= (state_nxt_s == DONE);
      opt_run        <= (state_nxt_s == OPT);
      exp_init       <= (state_nxt_s == EINIT);
      exp_run        <= (state_nxt_s == ERUN);
      exp_fin        <= (state_nxt_s == EFIN);
      distance_shift <= (state_nxt_s == SHIFT);
    end
  end

  // Run parameters, iteration count and inverse temperature.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_num_r   <= 32'd0;
      recip_step_r <= 17'd0;
      exp_recip    <= 17'd0;
      iter_cnt     <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      iter_num_r   <= iter_num;
      recip_step_r <= recip_step;
      exp_recip    <= recip_init;
      iter_cnt     <= 32'd0;
    end else if (state_r == EFIN) begin
      exp_recip    <= sat_add(exp_recip, recip_step_r);
      iter_cnt     <= iter_cnt + 32'd1;
    end else begin
      exp_recip    <= exp_recip;
      iter_cnt     <= iter_cnt;
    end
  end

endmodule

// File: doc/anneal_ctrl.md
ANNEAL_CTRL -- requirements
Module: anneal_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NODE_NUM, default 32: number of replica nodes and the length of the distance_shift readout in cycles.
REQ-003 Parameter EXP_LEN, default 17: number of cycles exp_run is held high in each iteration.
REQ-004 Parameter OPT_LAT, default 8: number of wait cycles after the opt_run pulse, covering the node opt pipeline latency.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle run request.
REQ-008 abort  in  1  single-cycle request to finish early.
REQ-009 iter_num  in  32  total number of iterations.
REQ-010 recip_init  in  17  initial inverse-temperature value.
REQ-011 recip_step  in  17  amount added to the inverse temperature after each iteration.
REQ-012 busy  out  1  run in progress.
REQ-013 done  out  1  single-cycle completion pulse.
REQ-014 opt_run  out  1  single-cycle opt pulse to the nodes.
REQ-015 exp_init  out  1  exp pipeline initialise strobe to the nodes.
REQ-016 exp_run  out  1  exp pipeline run enable to the nodes.
REQ-017 exp_fin  out  1  exp pipeline finish strobe to the nodes.
REQ-018 exp_recip  out  17  current inverse temperature, broadcast to the nodes.
REQ-019 distance_shift  out  1  total-distance readout shift enable to the nodes.
REQ-020 iter_cnt  out  32  number of completed iterations.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, OPT, WAIT, EINIT, ERUN, EFIN, SHIFT, DONE.
REQ-022 When start=1 in IDLE, the block SHALL latch iter_num and recip_step, load exp_recip with recip_init, clear iter_cnt, and set busy=1 from the next cycle.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 From IDLE on start, the next state SHALL be OPT if the latched iter_num is non-zero, otherwise SHIFT.
REQ-025 OPT SHALL last 1 cycle with opt_run=1, then go to WAIT.
REQ-026 WAIT SHALL last exactly OPT_LAT cycles with all strobes low, then go to EINIT.
REQ-027 EINIT SHALL last 1 cycle with exp_init=1.
REQ-028 ERUN SHALL last exactly EXP_LEN cycles with exp_run=1.
REQ-029 EFIN SHALL last 1 cycle with exp_fin=1.
REQ-030 Each iteration SHALL be exactly OPT_LAT+EXP_LEN+3 cycles long, i.e. 28 cycles at the default parameters.
REQ-031 In the EFIN cycle, iter_cnt SHALL increment by 1, effective on the next cycle.
REQ-032 In the EFIN cycle, exp_recip SHALL update to exp_recip+recip_step, computed at 18 bits and saturated to 17'h1FFFF, effective on the next cycle.
REQ-033 exp_recip SHALL stay constant during every state other than the EFIN update.
REQ-034 After EFIN, the next state SHALL be SHIFT if iter_cnt+1 equals the latched iter_num or an abort is pending, otherwise OPT.
REQ-035 abort SHALL be ignored in IDLE, SHIFT and DONE.
REQ-036 In OPT through EFIN, abort SHALL set a sticky pending flag, and the current iteration SHALL still complete in full.
REQ-037 The pending-abort flag SHALL be cleared on entry to SHIFT.
REQ-038 When abort and EFIN coincide, the abort SHALL take effect at that same EFIN.
REQ-039 SHIFT SHALL hold distance_shift=1 for exactly NODE_NUM consecutive cycles, then go to DONE.
REQ-040 DONE SHALL last 1 cycle with done=1 and busy=1, then go to IDLE, where busy=0.
REQ-041 iter_cnt and exp_recip SHALL hold their final values in IDLE until the next accepted start.
REQ-042 Only one of opt_run, exp_init, exp_run, exp_fin and distance_shift SHALL be high in any cycle.
REQ-043 The internal cycle counter SHALL be at least max(OPT_LAT, EXP_LEN, NODE_NUM) wide and SHALL be reloaded on every state entry.
REQ-044 All outputs SHALL be registered.

Reset
REQ-045 Reset SHALL put the FSM in IDLE and clear busy, done, opt_run, exp_init, exp_run, exp_fin, distance_shift, iter_cnt, the pending-abort flag and the internal counter.
REQ-046 Reset SHALL set exp_recip to 0.
REQ-047 Reset SHALL take priority over start and abort in the same cycle.
REQ-048 Reset asserted mid-run SHALL abandon the run without producing done or distance_shift.

Verification
REQ-049 The bench SHALL cover: iter_num=3, recip_init=100, recip_step=50 -> three 28-cycle iterations, exp_recip reading 100/150/200 during them and 250 at done, then 32 distance_shift cycles, then a done pulse, with iter_cnt=3.
REQ-050 The bench SHALL cover: iter_num=0 -> distance_shift high for 32 cycles starting 1 cycle after start, then done, with no opt_run and no exp strobes.
REQ-051 The bench SHALL cover: iter_num=10, abort pulsed during iteration 2 ERUN -> iteration 2 completes, iter_cnt=2, then SHIFT and done.
REQ-052 The bench SHALL cover: recip_init=17'h1FF00, recip_step=17'h00200 -> exp_recip saturates at 17'h1FFFF after the first EFIN and stays there.
REQ-053 The bench SHALL cover: start re-pulsed while busy, and abort pulsed during SHIFT -> no effect, identical timing to an undisturbed run.
REQ-054 The bench SHALL cover: reset asserted in the 5th ERUN cycle -> the next cycle shows IDLE, all outputs 0, no done; a new start then runs normally.
